drp_timeout: RTL
================

# drp_timeout

Registered DRP guard stage placed between the Wishbone DRP shim's DRP master port and a hard-block DRP target (transceiver, MMCM, XADC). It registers each request, forwards it as a single-cycle strobe, and returns the target's response one cycle later. If the target never asserts ready, the stage fabricates a response after a bounded time, so the upstream Wishbone cycle and the XFCP transaction behind it always terminate. Late responses from a timed-out target are absorbed and never reach the master.

## Interface
- ADDR_WIDTH, 16, DRP address width
- TIMEOUT, 255, cycles to wait for m_drp_rdy after m_drp_en; legal range 1..65535
- TIMEOUT_DATA, 16'hDEAD, read data returned on timeout

- clk  in  1  clock; one clock domain
- rst  in  1  reset; asynchronous, active-high
- s_drp_addr  in  ADDR_WIDTH  request address from upstream master
- s_drp_di  in  16  write data from master
- s_drp_do  out  16  read data to master
- s_drp_en  in  1  request strobe, one cycle per transaction
- s_drp_we  in  1  write qualifier, valid with s_drp_en
- s_drp_rdy  out  1  response strobe to master, one cycle
- m_drp_addr  out  ADDR_WIDTH  address to target
- m_drp_do  out  16  write data to target
- m_drp_di  in  16  read data from target
- m_drp_en  out  1  request strobe to target, one cycle
- m_drp_we  out  1  write strobe to target
- m_drp_rdy  in  1  target response strobe
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  one-cycle pulse, coincident with a fabricated s_drp_rdy

## Operation
- Reset values: all outputs 0; s_drp_do 0; counter 0; pending 0; state IDLE.
- IDLE: on s_drp_en, capture addr, di and we into request registers; go to ISSUE.
- ISSUE, one cycle: m_drp_en=1, m_drp_we=captured we; m_drp_addr and m_drp_do driven from request registers and held stable until the next capture; counter cleared; go to WAIT.
- WAIT: counter increments each cycle.
  - m_drp_rdy=1: latch m_drp_di into s_drp_do; pulse s_drp_rdy next cycle; go to IDLE.
  - Counter reaches TIMEOUT with no rdy: pulse s_drp_rdy with s_drp_do=TIMEOUT_DATA, pulse timeout_err, clear counter, go to RECOVER.
  - m_drp_rdy wins if it coincides with the terminal count.
- RECOVER: absorb the stale response.
  - Exit on m_drp_rdy (discarded; s_drp_do unchanged) or when the counter reaches TIMEOUT again.
  - Exit goes to ISSUE if pending is set (pending then clears), else to IDLE.
  - s_drp_en in RECOVER captures the request registers and sets pending.
- s_drp_en in ISSUE or WAIT violates the protocol: ignored, no capture.
- m_drp_rdy in IDLE or ISSUE is ignored.
- Counter width: clog2(TIMEOUT+1); no wrap.

## Timing
- s_drp_en at cycle 0 -> m_drp_en at cycle 1.
- m_drp_rdy at cycle k (2 <= k <= TIMEOUT+1) -> s_drp_rdy and data at cycle k+1.
- Without rdy, the fabricated s_drp_rdy and timeout_err occur at cycle TIMEOUT+2.
- Minimum request-to-response latency: 3 cycles. Back-to-back: a new s_drp_en is accepted in the same cycle s_drp_rdy is high.
- Asynchronous reset mid-transaction returns to IDLE and drops any pending request; no s_drp_rdy is produced for it.

## Configuration
- DRP_TIMEOUT_EN defined: timeout and RECOVER logic as described above.
- DRP_TIMEOUT_EN undefined: counter and RECOVER are removed; WAIT holds indefinitely for m_drp_rdy; timeout_err is tied 0; TIMEOUT and TIMEOUT_DATA are unused. Registration and latency are unchanged.

## Test plan
- Read, TIMEOUT=8, s_drp_en at cycle 0 with addr 0x0042, target rdy at cycle 4 with 0x1234 -> m_drp_en at cycle 1 with addr 0x0042 and we=0; s_drp_rdy at cycle 5 with s_drp_do 0x1234; timeout_err stays 0.
- Write of 0xBEEF to 0x0010, rdy at cycle 2 -> m_drp_we=1 and m_drp_do=0xBEEF at cycle 1; s_drp_rdy at cycle 3.
- Target silent, TIMEOUT=8 -> s_drp_rdy and timeout_err at cycle 10 with s_drp_do 0xDEAD; busy stays 1 in RECOVER. Late rdy at cycle 13 -> no s_drp_rdy; busy falls at cycle 14.
- Boundary, rdy at cycle 9 -> normal response at cycle 10 with target data; no timeout_err. New s_drp_en during RECOVER -> m_drp_en issued the cycle after RECOVER exits.
- Reset asserted at cycle 5 of a WAIT -> all outputs 0 immediately; later stale rdy ignored; a subsequent request completes normally.
- DRP_TIMEOUT_EN undefined, rdy at cycle 40 with TIMEOUT=8 -> s_drp_rdy at cycle 41 with target data; timeout_err never asserts.

Source files
------------

// File: rtl/drp_timeout.sv
// Registered DRP guard stage: forwards one request at a time and returns the
// target's response a cycle later. Optional timeout/recovery via DRP_TIMEOUT_EN.
module drp_timeout #(
  parameter int          ADDR_WIDTH   = 16,
  parameter int          TIMEOUT      = 255,
  parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_drp_addr,
  input  logic [15:0]           s_drp_di,
  output logic [15:0]           s_drp_do,
  input  logic                  s_drp_en,
  input  logic                  s_drp_we,
  output logic                  s_drp_rdy,
  output logic [ADDR_WIDTH-1:0] m_drp_addr,
  output logic [15:0]           m_drp_do,
  input  logic [15:0]           m_drp_di,
  output logic                  m_drp_en,
  output logic                  m_drp_we,
  input  logic                  m_drp_rdy,
  output logic                  busy,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t state_r;
  logic   timeout_s;

  if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
    $error("drp_timeout: TIMEOUT must lie in 1..65535");
  end

`ifdef DRP_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             pending_r;
  logic             req_we_r;
  logic             term_s;
  logic             recover_exit_s;

  // Terminal-count decode; the counter is one behind the cycle it is checked in,
  // so matching TIMEOUT-1 lands the fabricated response at request + TIMEOUT + 2.
  always_comb begin
    term_s         = (cnt_r == CNT_TERM);
    timeout_s      = (state_r == WAIT) && !m_drp_rdy && term_s;
    recover_exit_s = (state_r == RECOVER) && (m_drp_rdy || term_s);
  end

  // Wait/recover cycle counter: cleared on issue and on entry to RECOVER.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else begin
      case (state_r)
        ISSUE:   cnt_r <= CNT_ZERO;
        WAIT:    cnt_r <= timeout_s ? CNT_ZERO : (cnt_r + CNT_ONE);
        RECOVER: cnt_r <= recover_exit_s ? CNT_ZERO : (cnt_r + CNT_ONE);
        default: cnt_r <= cnt_r;
      endcase
    end
  end
`else
  // Without the timeout feature the stage waits for the target indefinitely.
  always_comb begin
    timeout_s = 1'b0;
  end
`endif

  // Request/response FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      m_drp_addr  <= {ADDR_WIDTH{1'b0}};
      m_drp_do    <= 16'h0000;
      m_drp_en    <= 1'b0;
      m_drp_we    <= 1'b0;
      s_drp_do    <= 16'h0000;
      s_drp_rdy   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
`ifdef DRP_TIMEOUT_EN
      pending_r   <= 1'b0;
      req_we_r    <= 1'b0;
`endif
    end else begin
      m_drp_en    <= 1'b0;
      m_drp_we    <= 1'b0;
      s_drp_rdy   <= 1'b0;
      timeout_err <= timeout_s;
      case (state_r)
        IDLE: begin
          if (s_drp_en) begin
            m_drp_addr <= s_drp_addr;
            m_drp_do   <= s_drp_di;
`ifdef DRP_TIMEOUT_EN
            req_we_r   <= s_drp_we;
`endif
            m_drp_en   <= 1'b1;
            m_drp_we   <= s_drp_we;
            busy       <= 1'b1;
            state_r    <= ISSUE;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          busy    <= 1'b1;
          state_r <= WAIT;
        end
        WAIT: begin
          // A real response beats a coincident terminal count.
          if (m_drp_rdy || timeout_s) begin
            s_drp_do  <= m_drp_rdy ? m_drp_di : TIMEOUT_DATA;
            s_drp_rdy <= 1'b1;
            if (m_drp_rdy) begin
              busy    <= 1'b0;
              state_r <= IDLE;
            end else begin
              busy    <= 1'b1;
              state_r <= RECOVER;
            end
          end else begin
            busy    <= 1'b1;
            state_r <= WAIT;
          end
        end
`ifdef DRP_TIMEOUT_EN
        RECOVER: begin
          if (s_drp_en) begin
            m_drp_addr <= s_drp_addr;
            m_drp_do   <= s_drp_di;
            req_we_r   <= s_drp_we;
          end else begin
            req_we_r   <= req_we_r;
          end
          // A request arriving on the exit cycle is issued directly.
          if (recover_exit_s) begin
            if (pending_r || s_drp_en) begin
              m_drp_en  <= 1'b1;
              m_drp_we  <= s_drp_en ? s_drp_we : req_we_r;
              pending_r <= 1'b0;
              busy      <= 1'b1;
              state_r   <= ISSUE;
            end else begin
              busy    <= 1'b0;
              state_r <= IDLE;
            end
          end else begin
            pending_r <= pending_r | s_drp_en;
            busy      <= 1'b1;
            state_r   <= RECOVER;
          end
        end
`endif
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
